// File: rtl/prog_loader_if.sv
// Host word stream and instruction-memory write port of the program loader.
// The loader uses the slave modport; the host/memory side uses master.
interface prog_loader_if #(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
);

  logic         ld_valid;
  logic [W-1:0] ld_data;
  logic         ld_last;
  logic         ld_ready;
  logic         im_wr_en;
  logic [D-1:0] im_wr_addr;
  logic [W-1:0] im_wr_data;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready,
    input  im_wr_en,
    input  im_wr_addr,
    input  im_wr_data
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready,
    output im_wr_en,
    output im_wr_addr,
    output im_wr_data
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader and run controller for the 9-bit accumulator core.
// Streams host words into instruction memory from address 0, pulses
// core_start for one cycle, then times the run until core_done.
// Optional feature: define PROG_LOADER_CKSUM_EN to require one checksum word
// (sum mod 2^W of the program) after the ld_last word before starting.
module prog_loader #(
  parameter int unsigned D       = 12,
  parameter int unsigned W       = 9,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus,
  output logic          core_start,
  input  logic          core_done,
  output logic [D:0]    prog_len,
  output logic [31:0]   run_cycles,
  output logic          ld_done,
  output logic          ld_err
);

  localparam int unsigned PL_W = D + 1;
  localparam int unsigned RC_W = 32;
  localparam logic [D-1:0]    ADDR_LAST = {D{1'b1}};
  localparam logic [RC_W-1:0] RUN_LIMIT = RC_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CKSUM,
    START,
    RUN,
    DONE,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    wr_ptr_q, wr_ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [D-1:0]    wr_addr_q, wr_addr_d;
  logic [W-1:0]    wr_data_q, wr_data_d;
  logic            start_q, start_d;
  logic [PL_W-1:0] prog_len_q, prog_len_d;
  logic [RC_W-1:0] run_q, run_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_c;
  logic            hs_c;

  // Ready depends on state only so the host can never see a valid->ready path
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      IDLE, LOAD, CKSUM, DONE: ready_c = 1'b1;
      default:                 ready_c = 1'b0;
    endcase
  end

  assign hs_c = bus.ld_valid & ready_c;

`ifdef PROG_LOADER_CKSUM_EN
  logic [W-1:0] sum_q;

  // Running sum of accepted program words; restarts with the first word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (hs_c) begin
      if (state_q == LOAD) begin
        sum_q <= sum_q + bus.ld_data;
      end else if (state_q == IDLE || state_q == DONE) begin
        sum_q <= bus.ld_data;
      end
    end
  end
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_d    = 1'b0;
    prog_len_d = prog_len_q;
    run_d      = run_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (hs_c) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_data_d  = bus.ld_data;
          wr_ptr_d   = D'(1);
          prog_len_d = PL_W'(1);
          run_d      = '0;
          done_d     = 1'b0;
          if (bus.ld_last) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = CKSUM;
`else
            state_d = START;
            start_d = 1'b1;
`endif
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (hs_c) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = wr_ptr_q;
          wr_data_d  = bus.ld_data;
          wr_ptr_d   = wr_ptr_q + D'(1);
          prog_len_d = prog_len_q + PL_W'(1);
          if (bus.ld_last) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = CKSUM;
`else
            state_d = START;
            start_d = 1'b1;
`endif
          end else if (wr_ptr_q == ADDR_LAST) begin
            // Memory full and no end marker: the word lands, then we stop
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: begin
        if (hs_c) begin
          if (bus.ld_data == sum_q) begin
            state_d = START;
            start_d = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      START: begin
        // core_done is not trusted here: the core PC still reflects the old run
        state_d = RUN;
        run_d   = '0;
      end

      RUN: begin
        if (core_done) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          run_d = run_q + RC_W'(1);
          if (run_q + RC_W'(1) == RUN_LIMIT) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      prog_len_q <= '0;
      run_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      prog_len_q <= prog_len_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.ld_ready   = ready_c;
  assign bus.im_wr_en   = wr_en_q;
  assign bus.im_wr_addr = wr_addr_q;
  assign bus.im_wr_data = wr_data_q;
  assign core_start     = start_q;
  assign prog_len       = prog_len_q;
  assign run_cycles     = run_q;
  assign ld_done        = done_q;
  assign ld_err         = err_q;

endmodule
